// File: rtl/exe_alu_mul_stage_pkg.sv
// exe_alu_mul_stage_pkg
// Shared definitions for the EX-stage ALU / iterative multiplier slice:
//   - exe_cmd operation encodings
//   - multiply-sequencer FSM state type
//   - bit positions of the {N,Z,C,V} flags inside a 4-bit status word
//   - a helper that derives the N and Z flags from a 32-bit result
package exe_alu_mul_stage_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;
  localparam logic [3:0] CMD_MLA = 4'b1011;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Returns {N, Z} for a 32-bit result.
  function automatic logic [1:0] calc_nz(input logic [31:0] r);
    return {r[31], (r == 32'h0000_0000)};
  endfunction

endpackage

// File: rtl/exe_alu_mul_stage_if.sv
// exe_alu_mul_stage_if
// Bundles the EX-stage instruction inputs and the result/flag/stall outputs.
//   master : the pipeline side that presents instructions and consumes results
//   slave  : the EX-stage block (exe_alu_mul_stage)
// Signals:
//   in_valid, flush, s_bit, exe_cmd[3:0], val_rn[31:0], val2[31:0],
//   val_acc[31:0], status_in[3:0]          -> towards the EX stage
//   alu_result[31:0], result_valid, status_out[3:0], status_ld, stall
//                                           <- from the EX stage
interface exe_alu_mul_stage_if;

  logic        in_valid;
  logic        flush;
  logic        s_bit;
  logic [3:0]  exe_cmd;
  logic [31:0] val_rn;
  logic [31:0] val2;
  logic [31:0] val_acc;
  logic [3:0]  status_in;
  logic [31:0] alu_result;
  logic        result_valid;
  logic [3:0]  status_out;
  logic        status_ld;
  logic        stall;

  modport master (
    output in_valid, flush, s_bit, exe_cmd, val_rn, val2, val_acc, status_in,
    input  alu_result, result_valid, status_out, status_ld, stall
  );

  modport slave (
    input  in_valid, flush, s_bit, exe_cmd, val_rn, val2, val_acc, status_in,
    output alu_result, result_valid, status_out, status_ld, stall
  );

endinterface

// File: rtl/exe_alu_mul_stage_seq_multiplier.sv
// seq_multiplier
// Iterative 32x32 shift-add multiplier, one partial product per step.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   start         : load operands, clear product and step counter
//   abort         : abandon the operation in flight (no done pulse)
//   step          : perform one shift-add step
//   a_in, b_in    : multiplicand / multiplier captured on start
//   acc_in        : accumulator operand captured on start (for MLA)
//   prod_lo       : low 32 bits of the product accumulator
//   acc_out       : captured accumulator operand
//   last          : the next step is the final (32nd) one
//   done          : one-cycle pulse in the cycle after the final step
module seq_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        step,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] acc_in,
  output logic [31:0] prod_lo,
  output logic [31:0] acc_out,
  output logic        last,
  output logic        done
);

  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] acc_r;
  logic [63:0] prod_r;
  logic [4:0]  cnt_r;
  logic        done_r;
  logic [63:0] partial_s;

  // Partial product for the current step: A shifted by the step index when
  // the multiplier bit now at b_r[0] is set.
  always_comb begin
    partial_s = 64'h0;
    if (b_r[0]) begin
      partial_s = {32'h0000_0000, a_r} << cnt_r;
    end else begin
      partial_s = 64'h0;
    end
  end

  // Operand, product, counter and done-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r    <= 32'h0;
      b_r    <= 32'h0;
      acc_r  <= 32'h0;
      prod_r <= 64'h0;
      cnt_r  <= 5'd0;
      done_r <= 1'b0;
    end else if (start) begin
      a_r    <= a_in;
      b_r    <= b_in;
      acc_r  <= acc_in;
      prod_r <= 64'h0;
      cnt_r  <= 5'd0;
      done_r <= 1'b0;
    end else if (abort) begin
      cnt_r  <= 5'd0;
      done_r <= 1'b0;
    end else if (step) begin
      prod_r <= prod_r + partial_s;
      b_r    <= b_r >> 1;
      // counter wraps 31 -> 0 on the final step, ready for the next start
      cnt_r  <= cnt_r + 5'd1;
      done_r <= (cnt_r == 5'd31);
    end else begin
      done_r <= 1'b0;
    end
  end

  assign prod_lo = prod_r[31:0];
  assign acc_out = acc_r;
  assign last    = (cnt_r == 5'd31);
  assign done    = done_r;

endmodule

// File: rtl/exe_alu_mul_stage.sv
// exe_alu_mul_stage
// EX stage: single-cycle ALU for move/arithmetic/logic ops and a 34-cycle
// iterative MUL/MLA path that stalls the upstream pipeline while it runs.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   ex   : exe_alu_mul_stage_if.slave (instruction in, result/flags/stall out)
module exe_alu_mul_stage
  import exe_alu_mul_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  exe_alu_mul_stage_if.slave  ex
);

  state_e      state_r;
  state_e      next_state_s;
  logic [3:0]  op_r;
  logic        s_bit_r;

  logic        mul_req_s;
  logic        mul_start_s;
  logic        mul_abort_s;
  logic        mul_step_s;
  logic [31:0] mul_prod_lo_s;
  logic [31:0] mul_acc_s;
  logic        mul_last_s;
  logic        mul_done_s;
  logic [31:0] mul_res_s;

  logic [32:0] sum_s;
  logic        cin_s;
  logic [31:0] alu_res_s;
  logic        c_new_s;
  logic        v_new_s;
  logic        alu_nop_s;

  logic [31:0] alu_result_s;
  logic        result_valid_s;
  logic [3:0]  flags_new_s;
  logic [3:0]  status_out_s;
  logic        status_ld_s;
  logic        stall_s;

  assign mul_req_s   = ex.in_valid && !ex.flush &&
                       ((ex.exe_cmd == CMD_MUL) || (ex.exe_cmd == CMD_MLA));
  assign mul_start_s = (state_r == ST_IDLE) && mul_req_s;
  assign mul_abort_s = (state_r == ST_MULT) && ex.flush;
  assign mul_step_s  = (state_r == ST_MULT) && !ex.flush;
  assign mul_res_s   = mul_prod_lo_s + ((op_r == CMD_MLA) ? mul_acc_s : 32'h0);

  seq_multiplier u_seq_multiplier (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_s),
    .abort   (mul_abort_s),
    .step    (mul_step_s),
    .a_in    (ex.val_rn),
    .b_in    (ex.val2),
    .acc_in  (ex.val_acc),
    .prod_lo (mul_prod_lo_s),
    .acc_out (mul_acc_s),
    .last    (mul_last_s),
    .done    (mul_done_s)
  );

  // Single-cycle ALU. Subtraction is A + ~B + cin so the carry-out is NOT borrow.
  always_comb begin
    sum_s     = 33'h0;
    cin_s     = 1'b0;
    alu_res_s = 32'h0;
    c_new_s   = ex.status_in[FLAG_C];
    v_new_s   = ex.status_in[FLAG_V];
    alu_nop_s = 1'b0;
    case (ex.exe_cmd)
      CMD_MOV: alu_res_s = ex.val2;
      CMD_MVN: alu_res_s = ~ex.val2;
      CMD_ADD, CMD_ADC: begin
        cin_s     = (ex.exe_cmd == CMD_ADC) ? ex.status_in[FLAG_C] : 1'b0;
        sum_s     = {1'b0, ex.val_rn} + {1'b0, ex.val2} + {32'h0, cin_s};
        alu_res_s = sum_s[31:0];
        c_new_s   = sum_s[32];
        v_new_s   = (ex.val_rn[31] == ex.val2[31]) && (sum_s[31] != ex.val_rn[31]);
      end
      CMD_SUB, CMD_SBC: begin
        cin_s     = (ex.exe_cmd == CMD_SUB) ? 1'b1 : ex.status_in[FLAG_C];
        sum_s     = {1'b0, ex.val_rn} + {1'b0, ~ex.val2} + {32'h0, cin_s};
        alu_res_s = sum_s[31:0];
        c_new_s   = sum_s[32];
        v_new_s   = (ex.val_rn[31] != ex.val2[31]) && (sum_s[31] != ex.val_rn[31]);
      end
      CMD_AND: alu_res_s = ex.val_rn & ex.val2;
      CMD_ORR: alu_res_s = ex.val_rn | ex.val2;
      CMD_EOR: alu_res_s = ex.val_rn ^ ex.val2;
      default: alu_nop_s = 1'b1;
    endcase
  end

  // Next-state logic of the multiply sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mul_req_s) begin
          next_state_s = ST_MULT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MULT: begin
        if (ex.flush) begin
          next_state_s = ST_IDLE;
        end else if (mul_last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_MULT;
        end
      end
      // The EX inputs still hold the finished multiply here; they are ignored.
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register plus the opcode and flag-update request captured at accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      op_r    <= 4'h0;
      s_bit_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (mul_start_s) begin
        op_r    <= ex.exe_cmd;
        s_bit_r <= ex.s_bit;
      end else begin
        op_r    <= op_r;
        s_bit_r <= s_bit_r;
      end
    end
  end

  // Output decode: result, valid, flag update and stall for the current state.
  always_comb begin
    alu_result_s   = 32'h0;
    result_valid_s = 1'b0;
    flags_new_s    = ex.status_in;
    status_ld_s    = 1'b0;
    stall_s        = 1'b0;
    status_out_s   = 4'b0000;
    if (!rst) begin
      status_out_s = 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mul_req_s) begin
            stall_s = 1'b1;
          end else begin
            alu_result_s   = alu_res_s;
            result_valid_s = ex.in_valid && !ex.flush;
            status_ld_s    = result_valid_s && ex.s_bit;
            if (alu_nop_s) begin
              flags_new_s = ex.status_in;
            end else begin
              flags_new_s = {calc_nz(alu_res_s), c_new_s, v_new_s};
            end
          end
        end
        ST_MULT: stall_s = 1'b1;
        ST_DONE: begin
          alu_result_s   = mul_res_s;
          result_valid_s = mul_done_s;
          status_ld_s    = result_valid_s && s_bit_r;
          flags_new_s    = {calc_nz(mul_res_s), ex.status_in[FLAG_C], ex.status_in[FLAG_V]};
        end
        default: stall_s = 1'b0;
      endcase
      status_out_s = status_ld_s ? flags_new_s : ex.status_in;
    end
  end

  assign ex.alu_result   = alu_result_s;
  assign ex.result_valid = result_valid_s;
  assign ex.status_out   = status_out_s;
  assign ex.status_ld    = status_ld_s;
  assign ex.stall        = stall_s;

endmodule

// File: tb/tb_exe_alu_mul_stage.sv
// tb_exe_alu_mul_stage
// Directed-vector bench for exe_alu_mul_stage. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_exe_alu_mul_stage;
  import exe_alu_mul_stage_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   stall_cnt;
  int   guard;

  exe_alu_mul_stage_if ex_if ();

  exe_alu_mul_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (ex_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic s, input logic [3:0] cmd,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                       input logic [3:0] st);
    ex_if.in_valid  = v;
    ex_if.flush     = fl;
    ex_if.s_bit     = s;
    ex_if.exe_cmd   = cmd;
    ex_if.val_rn    = a;
    ex_if.val2      = b;
    ex_if.val_acc   = acc;
    ex_if.status_in = st;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_result"}, ex_if.alu_result, 32'h0);
    check_val({tag, "_valid"},  {31'h0, ex_if.result_valid}, 32'h0);
    check_val({tag, "_status"}, {28'h0, ex_if.status_out}, 32'h0);
    check_val({tag, "_ld"},     {31'h0, ex_if.status_ld}, 32'h0);
    check_val({tag, "_stall"},  {31'h0, ex_if.stall}, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    drive(1'b1, 1'b0, 1'b1, CMD_ADD, 32'h1234, 32'h1, 32'h0, 4'b1111);
    @(negedge clk); #1;
    check_all_zero("reset");

    @(negedge clk); rst = 1'b1;
    // ADD overflow into the sign bit
    drive(1'b1, 1'b0, 1'b1, CMD_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'b0000); #1;
    check_val("add_result", ex_if.alu_result, 32'h8000_0000);
    check_val("add_status", {28'h0, ex_if.status_out}, 32'h9);
    check_val("add_ld",     {31'h0, ex_if.status_ld}, 32'h1);
    check_val("add_valid",  {31'h0, ex_if.result_valid}, 32'h1);
    check_val("add_stall",  {31'h0, ex_if.stall}, 32'h0);

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, CMD_SUB, 32'h5, 32'h5, 32'h0, 4'b0000); #1;
    check_val("sub_result", ex_if.alu_result, 32'h0);
    check_val("sub_status", {28'h0, ex_if.status_out}, 32'h6);

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, CMD_SBC, 32'h3, 32'h1, 32'h0, 4'b0000); #1;
    check_val("sbc_result", ex_if.alu_result, 32'h1);
    check_val("sbc_status", {28'h0, ex_if.status_out}, 32'h2);

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, CMD_ORR, 32'hF0, 32'h0F, 32'h0, 4'b1010); #1;
    check_val("orr_result", ex_if.alu_result, 32'hFF);
    check_val("orr_ld",     {31'h0, ex_if.status_ld}, 32'h0);
    check_val("orr_status", {28'h0, ex_if.status_out}, 32'hA);

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, CMD_MVN, 32'h0, 32'h0, 32'h0, 4'b0001); #1;
    check_val("mvn_result", ex_if.alu_result, 32'hFFFF_FFFF);
    check_val("mvn_status", {28'h0, ex_if.status_out}, 32'h9);

    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 4'b0000, 32'h7, 32'h9, 32'h0, 4'b0101); #1;
    check_val("nop_result", ex_if.alu_result, 32'h0);
    check_val("nop_status", {28'h0, ex_if.status_out}, 32'h5);

    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, CMD_ADD, 32'h1, 32'h1, 32'h0, 4'b0000); #1;
    check_val("flush_alu_valid", {31'h0, ex_if.result_valid}, 32'h0);
    check_val("flush_alu_ld",    {31'h0, ex_if.status_ld}, 32'h0);

    // MLA: 0xFFFFFFFF*2 + 3 wraps to 1; C,V from status_in kept
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, CMD_MLA, 32'hFFFF_FFFF, 32'h2, 32'h3, 4'b0011); #1;
    stall_cnt = 0;
    guard = 0;
    while (ex_if.stall && guard < 100) begin
      stall_cnt++;
      guard++;
      @(negedge clk); #1;
    end
    check_val("mla_stall_cycles", stall_cnt, 33);
    check_val("mla_result", ex_if.alu_result, 32'h1);
    check_val("mla_valid",  {31'h0, ex_if.result_valid}, 32'h1);
    check_val("mla_status", {28'h0, ex_if.status_out}, 32'h3);
    check_val("mla_ld",     {31'h0, ex_if.status_ld}, 32'h1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'b0011); #1;
    check_val("mla_after_valid", {31'h0, ex_if.result_valid}, 32'h0);
    check_val("mla_after_stall", {31'h0, ex_if.stall}, 32'h0);

    // MUL with all-ones operands, no flag update
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, CMD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'b1100); #1;
    guard = 0;
    while (ex_if.stall && guard < 100) begin
      guard++;
      @(negedge clk); #1;
    end
    check_val("mul_ones_cycles", guard, 33);
    check_val("mul_ones_result", ex_if.alu_result, 32'h1);
    check_val("mul_ones_ld",     {31'h0, ex_if.status_ld}, 32'h0);
    check_val("mul_ones_status", {28'h0, ex_if.status_out}, 32'hC);

    // MUL flushed on its 10th MULT cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, CMD_MUL, 32'h3, 32'h4, 32'h0, 4'b0000);
    repeat (10) @(negedge clk);
    #1;
    check_val("flush_mult_stall", {31'h0, ex_if.stall}, 32'h1);
    ex_if.flush = 1'b1; #1;
    check_val("flush_mult_valid", {31'h0, ex_if.result_valid}, 32'h0);
    check_val("flush_mult_ld",    {31'h0, ex_if.status_ld}, 32'h0);
    @(negedge clk); #1;
    // back in IDLE; multiply with flush still present is not accepted
    check_val("flush_idle_stall", {31'h0, ex_if.stall}, 32'h0);
    check_val("flush_idle_valid", {31'h0, ex_if.result_valid}, 32'h0);
    @(negedge clk); #1;
    check_val("flush_noaccept_stall", {31'h0, ex_if.stall}, 32'h0);
    guard = 0;
    ex_if.flush = 1'b0;
    ex_if.in_valid = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (ex_if.result_valid) guard++;
    end
    check_val("flush_no_late_valid", guard, 0);

    // MUL interrupted by reset on its 20th cycle
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, CMD_MUL, 32'h7, 32'h6, 32'h0, 4'b1111);
    repeat (20) @(negedge clk);
    rst = 1'b0; #1;
    check_all_zero("rst_mult");
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, CMD_ADD, 32'h1, 32'h2, 32'h0, 4'b0000); #1;
    check_val("post_rst_result", ex_if.alu_result, 32'h3);
    check_val("post_rst_valid",  {31'h0, ex_if.result_valid}, 32'h1);
    check_val("post_rst_stall",  {31'h0, ex_if.stall}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'b0000);
    guard = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (ex_if.result_valid || ex_if.stall) guard++;
    end
    check_val("post_rst_quiet", guard, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exe_alu_mul_stage.md
EXE_ALU_MUL_STAGE -- requirements
Module: exe_alu_mul_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  — the single clock; all state is on the rising edge.
- rst  input  1  — asynchronous, active-low reset.
- in_valid  input  1  — an EX-stage instruction is present.
- flush  input  1  — the EX instruction is squashed (branch taken).
- s_bit  input  1  — the instruction requests a flag update.
- exe_cmd  input  4  — operation code.
- val_rn  input  32  — operand A.
- val2  input  32  — operand B (shifter output).
- val_acc  input  32  — MLA accumulator.
- status_in  input  4  — current flags {N,Z,C,V} from the status register.
- alu_result  output  32  — operation result.
- result_valid  output  1  — alu_result is valid this cycle.
- status_out  output  4  — new {N,Z,C,V}, sent to the status register's data input.
- status_ld  output  1  — load strobe for the status register.
- stall  output  1  — upstream stages must hold.

Function
REQ-002 exe_cmd encodings SHALL be:
- MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101.
- AND 0110, ORR 0111, EOR 1000, MUL 1010, MLA 1011.
- Any other code is a NOP: result 0, flags unchanged.
REQ-003 Non-multiply ops SHALL complete combinationally in the cycle they are presented: result_valid=in_valid&~flush, with stall=0.
REQ-004 ADD/ADC: result SHALL be A+B(+C_in); C = carry-out of bit 31; V = (A[31]==B[31]) && (R[31]!=A[31]).
REQ-005 SUB/SBC: result SHALL be A-B(-~C_in); C = NOT borrow; V = (A[31]!=B[31]) && (R[31]!=A[31]).
REQ-006 Logic ops, MOV and MVN SHALL compute N and Z and pass C and V through from status_in.
REQ-007 For every operation, N = R[31] and Z = (R==0).
REQ-008 status_out SHALL equal status_in whenever status_ld=0.
REQ-009 status_ld SHALL be result_valid & s_bit, where s_bit is the value latched at accept for MUL/MLA.
REQ-010 The FSM SHALL have states IDLE, MULT and DONE.
REQ-011 IDLE -> MULT SHALL occur when in_valid & ~flush & exe_cmd in {MUL, MLA}; on that transition the block latches A, B, acc, s_bit and the op, and clears a 5-bit counter.
REQ-012 MULT SHALL perform one shift-add step per cycle for 32 cycles (counter 0..31), then move to DONE.
REQ-013 stall SHALL be 1 in the accept cycle and throughout MULT, and 0 in IDLE and DONE.
REQ-014 In DONE, for one cycle:
- alu_result SHALL be low32(A*B), plus acc for MLA, with wrap-around.
- result_valid SHALL be 1.
- N and Z SHALL be updated; C and V SHALL be preserved.
- The next state SHALL be IDLE.
- The EX inputs still holding the completed multiply SHALL be ignored.
REQ-015 Multiply latency SHALL be 34 cycles, from the accept edge to the DONE output, inclusive.
REQ-016 Asserting flush in MULT SHALL return the FSM to IDLE on the next edge, with no result_valid and no status_ld.
REQ-017 flush together with a multiply in IDLE SHALL prevent the multiply from being accepted.
REQ-018 Operand values of 0 or 0xFFFFFFFF SHALL need no special case: the result is the exact low 32 bits of the product.

Reset
REQ-019 While rst=0, the block SHALL set:
- state to IDLE and the counter to 0;
- all latched operands to 0;
- stall, result_valid and status_ld to 0;
- alu_result to 0 and status_out to 4'b0000.
REQ-020 Reset during MULT SHALL abandon the operation with no flag update.
REQ-021 After rst rises, the first edge SHALL accept a new instruction normally.

Structure
REQ-022 A shared package SHALL hold:
- the exe_cmd encoding constants;
- the FSM state enum;
- the flag bit indices N=3, Z=2, C=1, V=0.
REQ-023 The iterative datapath SHALL be a single sub-module, seq_multiplier, containing the operand registers, the 64-bit product accumulator, the counter and a done pulse. The ALU and flag logic SHALL stay in exe_alu_mul_stage.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- ADD, s_bit=1, A=0x7FFFFFFF, B=1 -> result 0x80000000, status_out 1001, status_ld=1.
- SUB, s_bit=1, A=5, B=5 -> result 0, status_out 0110 (Z=1, C=1).
- SBC, status_in C=0, A=3, B=1 -> result 1, C=1.
- ORR, s_bit=0 -> status_ld=0 and status_out equals status_in.
- MLA, s_bit=1, A=0xFFFFFFFF, B=2, acc=3, status_in 0011 -> stall for 33 cycles, then DONE with result 0x00000001 and status_out 0011.
- MUL in progress with flush on cycle 10 -> IDLE next cycle, no result_valid; likewise rst=0 on cycle 20 -> all outputs 0.
